// File: rtl/codes_pkg.sv
// Shared CPU codes: operand width, ALU function fields and
// multiply/divide sequencer state.
package codes;

  typedef logic [31:0] size_t;

  typedef enum logic [5:0] {
    FUNC_MFHI  = 6'h10,
    FUNC_MTHI  = 6'h11,
    FUNC_MFLO  = 6'h12,
    FUNC_MTLO  = 6'h13,
    FUNC_MULT  = 6'h18,
    FUNC_MULTU = 6'h19,
    FUNC_DIV   = 6'h1a,
    FUNC_DIVU  = 6'h1b,
    FUNC_ADD   = 6'h20,
    FUNC_ADDU  = 6'h21,
    FUNC_SUB   = 6'h22,
    FUNC_SUBU  = 6'h23,
    FUNC_AND   = 6'h24,
    FUNC_OR    = 6'h25,
    FUNC_XOR   = 6'h26,
    FUNC_NOR   = 6'h27,
    FUNC_SLT   = 6'h2a,
    FUNC_SLTU  = 6'h2b
  } func_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX
  } md_state_t;

  localparam int MD_ITERATIONS = 32;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO.
// Works on magnitudes; signs are restored in a single fixup cycle.
module muldiv_unit
  import codes::*;
(
  input  logic  clk,
  input  logic  reset_i,
  input  logic  start_i,
  input  func_t funct_i,
  input  size_t rs_i,
  input  size_t rt_i,
  output logic  busy_o,
  output logic  done_o,
  output size_t hi_o,
  output size_t lo_o
);

  md_state_t   state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  size_t       a_q, a_d, b_q, b_d;
  size_t       hi_q, hi_d, lo_q, lo_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        div_q, div_d, done_q, done_d;

  logic        is_mul, is_div, is_sgn, last;
  logic [32:0] madd, rsh;
  logic        ge;
  size_t       rsub, quo, rem;
  logic [63:0] prod;

  function automatic logic [63:0] neg64(
    input logic [63:0] v,
    input logic        n
  );
    return n ? (~v + 64'd1) : v;
  endfunction

  function automatic size_t neg32(
    input size_t v,
    input logic  n
  );
    return n ? (~v + 32'd1) : v;
  endfunction

  assign is_mul = (funct_i == FUNC_MULT) || (funct_i == FUNC_MULTU);
  assign is_div = (funct_i == FUNC_DIV) || (funct_i == FUNC_DIVU);
  assign is_sgn = (funct_i == FUNC_MULT) || (funct_i == FUNC_DIV);
  assign last   = (cnt_q == 6'(MD_ITERATIONS - 1));

  // mul: upper half accumulates, whole product shifts right
  assign madd = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
  // div: partial remainder with next dividend bit shifted in
  assign rsh  = {acc_q[63:32], a_q[31]};
  assign ge   = (rsh >= {1'b0, b_q});
  assign rsub = rsh[31:0] - b_q;

  assign prod = neg64(acc_q, sa_q ^ sb_q);
  assign quo  = neg32(acc_q[31:0], sa_q ^ sb_q);
  assign rem  = neg32(acc_q[63:32], sa_q);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state_q <= MD_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i && is_mul)
          state_d = MD_MUL;
        else if (start_i && is_div)
          state_d = (rt_i == 32'd0) ? MD_FIX : MD_DIV;
      end
      MD_MUL:  if (last) state_d = MD_FIX;
      MD_DIV:  if (last) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    div_d  = div_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i && (is_mul || is_div)) begin
          sa_d  = is_sgn & rs_i[31];
          sb_d  = is_sgn & rt_i[31];
          a_d   = neg32(rs_i, is_sgn & rs_i[31]);
          b_d   = neg32(rt_i, is_sgn & rt_i[31]);
          div_d = is_div;
          acc_d = 64'd0;
          cnt_d = 6'd0;
        end else if (start_i && funct_i == FUNC_MTHI) begin
          hi_d = rs_i;
        end else if (start_i && funct_i == FUNC_MTLO) begin
          lo_d = rs_i;
        end
      end
      MD_MUL: begin
        acc_d = {madd, acc_q[31:1]};
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 6'd1;
      end
      MD_DIV: begin
        acc_d = {(ge ? rsub : rsh[31:0]), acc_q[30:0], ge};
        a_d   = a_q << 1;
        cnt_d = cnt_q + 6'd1;
      end
      MD_FIX: begin
        hi_d   = div_q ? rem : prod[63:32];
        lo_d   = div_q ? quo : prod[31:0];
        done_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      div_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    busy_o = (state_q != MD_IDLE);
    done_o = done_q;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {HI,LO} queued at issue,
// popped and compared by a monitor on every done pulse.
module tb_muldiv_unit;
  import codes::*;

  logic  clk = 1'b0;
  logic  reset_i;
  logic  start_i;
  func_t funct_i;
  size_t rs_i, rt_i;
  logic  busy_o, done_o;
  size_t hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk     (clk),
    .reset_i (reset_i),
    .start_i (start_i),
    .funct_i (funct_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_i === 1'b0 && done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h want no done",
                 hi_o, lo_o);
      end else begin
        logic [63:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(n, {hi_o, lo_o}, e);
      end
    end
  end

  function automatic logic [63:0] ref_model(func_t f, size_t a, size_t b);
    logic signed [63:0] pa, pb;
    logic signed [31:0] sa, sb, q, r;
    pa = $signed({{32{a[31]}}, a});
    pb = $signed({{32{b[31]}}, b});
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      FUNC_MULT:  return pa * pb;
      FUNC_MULTU: return {32'd0, a} * {32'd0, b};
      FUNC_DIV: begin
        if (b == 32'd0) return 64'd0;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff)
          return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      FUNC_DIVU: begin
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic issue(func_t f, size_t a, size_t b);
    funct_i = f;
    rs_i    = a;
    rt_i    = b;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy after %0d cycles want idle", n);
    end
  endtask

  task automatic run(string nm, func_t f, size_t a, size_t b,
                     logic [63:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    issue(f, a, b);
    wait_idle();
  endtask

  task automatic timed(string nm, func_t f, size_t a, size_t b,
                       logic [63:0] e, int busy_exp);
    int n, d;
    exp_q.push_back(e);
    name_q.push_back(nm);
    issue(f, a, b);
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 64'(n), 64'(busy_exp));
    d = 0;
    repeat (3) begin
      d += int'(done_o);
      @(negedge clk);
    end
    chk({nm, "_done_width"}, 64'(d), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    func_t ops[4];
    size_t cv[4];
    size_t a, b;
    ops = '{FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
    cv  = '{32'd0, 32'd1, 32'hffff_ffff, 32'h8000_0000};

    reset_i = 1'b1;
    start_i = 1'b0;
    funct_i = FUNC_ADD;
    rs_i    = '0;
    rt_i    = '0;
    #1;
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_flags", {62'd0, busy_o, done_o}, 64'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);

    issue(FUNC_MTLO, 32'h1234_5678, 32'd0);
    chk("mtlo_value", {32'd0, lo_o}, {32'd0, 32'h1234_5678});
    chk("mtlo_busy", {63'd0, busy_o}, 64'd0);
    issue(FUNC_MTHI, 32'hcafe_f00d, 32'd0);
    chk("mthi_value", {hi_o, lo_o}, {32'hcafe_f00d, 32'h1234_5678});

    timed("multu_max", FUNC_MULTU, 32'hffff_ffff, 32'hffff_ffff,
          {32'hffff_fffe, 32'h0000_0001}, 33);
    timed("divu_by_zero", FUNC_DIVU, 32'd5, 32'd0, 64'd0, 1);

    run("mult_m3_7", FUNC_MULT, 32'hffff_fffd, 32'd7,
        {32'hffff_ffff, 32'hffff_ffeb});
    run("div_m7_2", FUNC_DIV, 32'hffff_fff9, 32'd2,
        {32'hffff_ffff, 32'hffff_fffd});
    run("div_ovf", FUNC_DIV, 32'h8000_0000, 32'hffff_ffff,
        {32'd0, 32'h8000_0000});
    run("mult_min_min", FUNC_MULT, 32'h8000_0000, 32'h8000_0000,
        {32'h4000_0000, 32'd0});
    run("mult_max_m1", FUNC_MULT, 32'h7fff_ffff, 32'hffff_ffff,
        {32'hffff_ffff, 32'h8000_0001});
    run("div_7_m2", FUNC_DIV, 32'd7, 32'hffff_fffe,
        {32'd1, 32'hffff_fffd});
    run("div_m8_m3", FUNC_DIV, 32'hffff_fff8, 32'hffff_fffd,
        {32'hffff_fffe, 32'd2});
    run("divu_max_1", FUNC_DIVU, 32'hffff_ffff, 32'd1,
        {32'd0, 32'hffff_ffff});
    run("divu_min_max", FUNC_DIVU, 32'h8000_0000, 32'hffff_ffff,
        {32'h8000_0000, 32'd0});
    run("multu_2p16", FUNC_MULTU, 32'h0001_0000, 32'h0001_0000,
        {32'd1, 32'd0});
    run("div_m5_0", FUNC_DIV, 32'hffff_fffb, 32'd0, 64'd0);

    exp_q.push_back({32'hffff_ffff, 32'hffff_ffeb});
    name_q.push_back("mthi_while_busy");
    issue(FUNC_MULT, 32'hffff_fffd, 32'd7);
    repeat (5) @(negedge clk);
    issue(FUNC_MTHI, 32'hdead_beef, 32'd0);
    wait_idle();

    issue(FUNC_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    chk("abort_hilo", {hi_o, lo_o}, 64'd0);
    chk("abort_flags", {62'd0, busy_o, done_o}, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_write", {hi_o, lo_o}, 64'd0);
    run("divu_100_7", FUNC_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});

    foreach (ops[i])
      foreach (cv[j])
        foreach (cv[k])
          run($sformatf("corner_%s_%h_%h", ops[i].name(), cv[j], cv[k]),
              ops[i], cv[j], cv[k], ref_model(ops[i], cv[j], cv[k]));

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? size_t'($urandom_range(1, 300)) : $urandom;
      run($sformatf("rand_%s_%h_%h", ops[i % 4].name(), a, b),
          ops[i % 4], a, b, ref_model(ops[i % 4], a, b));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
